// File: rtl/uart_word_tx.sv
// Word-to-byte UART feeder: buffers W_D-bit words in a small FIFO and hands them
// to a byte-wide UART transmitter LSB first, using a READY/WE strobe handshake.
module uart_word_tx #(
  parameter int W_D           = 32,
  parameter int FIFO_ADDR_LEN = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [W_D-1:0]         IN_DATA,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  output logic [7:0]             TX_DATA,
  output logic                   TX_WE,
  input  logic                   TX_READY,
  output logic                   BUSY,
  output logic                   WORD_DONE,
  output logic [FIFO_ADDR_LEN:0] COUNT
);

  localparam int NB    = W_D / 8;
  localparam int DEPTH = 1 << FIFO_ADDR_LEN;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NB - 1);
  localparam logic [IDX_W-1:0]         IDX_ONE  = IDX_W'(1);
  localparam logic [FIFO_ADDR_LEN-1:0] PTR_ONE  = FIFO_ADDR_LEN'(1);
  localparam logic [FIFO_ADDR_LEN:0]   CNT_ONE  = (FIFO_ADDR_LEN + 1)'(1);
  localparam logic [FIFO_ADDR_LEN:0]   DEPTH_C  = (FIFO_ADDR_LEN + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_RDY  = 3'd2,
    WAIT_BUSY = 3'd3,
    DONE      = 3'd4
  } state_e;

  logic [W_D-1:0]           mem_q [DEPTH];
  logic [FIFO_ADDR_LEN-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_LEN-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR_LEN:0]   count_q, count_d;

  state_e                   state_q, state_d;
  logic [W_D-1:0]           shift_q, shift_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [7:0]               tx_data_q, tx_data_d;
  logic                     tx_we_q, tx_we_d;
  logic                     word_done_q, word_done_d;

  logic                     push;
  logic                     pop;

  assign IN_READY  = (count_q < DEPTH_C);
  assign push      = IN_VALID && IN_READY;
  assign pop       = (state_q == IDLE) && (count_q != '0);

  assign TX_DATA   = tx_data_q;
  assign TX_WE     = tx_we_q;
  assign WORD_DONE = word_done_q;
  assign COUNT     = count_q;
  assign BUSY      = (state_q != IDLE) || (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // A simultaneous push and pop leaves the occupancy untouched.
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= IN_DATA;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    tx_data_d   = tx_data_q;
    tx_we_d     = tx_we_q;
    word_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        idx_d   = '0;
        state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (TX_READY) begin
          tx_we_d   = 1'b1;
          tx_data_d = shift_q[7:0];
          state_d   = WAIT_BUSY;
        end else begin
          state_d = WAIT_RDY;
        end
      end
      WAIT_BUSY: begin
        // Strobe stays up until the transmitter has visibly taken the byte.
        if (!TX_READY) begin
          tx_we_d = 1'b0;
          shift_d = shift_q >> 8;
          idx_d   = idx_q + IDX_ONE;
          if (idx_q == LAST_IDX) begin
            state_d     = DONE;
            word_done_d = 1'b1;
          end else begin
            state_d = WAIT_RDY;
          end
        end else begin
          state_d = WAIT_BUSY;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      tx_data_q   <= 8'h00;
      tx_we_q     <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      tx_data_q   <= tx_data_d;
      tx_we_q     <= tx_we_d;
      word_done_q <= word_done_d;
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: directed scenarios plus random traffic against a
// byte-queue reference model and a behavioural UART transmitter model.
module tb_uart_word_tx;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  tx_data;
  logic        tx_we;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        word_done;
  logic [2:0]  count;

  always #5 clk = ~clk;

  uart_word_tx #(.W_D(32), .FIFO_ADDR_LEN(2)) dut (
    .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid),
    .IN_READY(in_ready), .TX_DATA(tx_data), .TX_WE(tx_we),
    .TX_READY(tx_ready), .BUSY(busy), .WORD_DONE(word_done), .COUNT(count)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic we_prev = 1'b0;
  logic wd_prev = 1'b0;
  int done_cnt = 0;
  int byte_cnt = 0;

  // Transmitter model: READY drops some cycles after WE, returns after a busy period.
  bit tx_auto = 1'b1;
  int tx_phase = 0;
  int tx_cnt = 0;
  int tx_dly_max = 0;
  int tx_len_min = 10;
  int tx_len_max = 10;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic step();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (tx_we && !we_prev) begin
      byte_cnt++;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = 8'bx;
      check("tx byte", {24'h0, tx_data}, {24'h0, e});
    end
    if (word_done) begin
      done_cnt++;
      check("word_done one cycle", {31'h0, wd_prev}, 32'h0);
    end
    we_prev = tx_we;
    wd_prev = word_done;
    if (tx_auto && !rst) begin
      if (tx_phase == 2) begin
        if (tx_cnt == 0) begin
          tx_ready = 1'b1;
          tx_phase = 0;
        end else tx_cnt--;
      end else if (tx_phase == 0 && tx_we) begin
        tx_cnt = int'($urandom_range(tx_dly_max, 0));
        tx_phase = 1;
      end
      if (tx_phase == 1) begin
        if (tx_cnt == 0) begin
          tx_ready = 1'b0;
          tx_phase = 2;
          tx_cnt = int'($urandom_range(tx_len_max, tx_len_min));
        end else tx_cnt--;
      end
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((busy || exp_q.size() != 0 || tx_phase != 0) && n < 5000) begin
      step();
      n++;
    end
    check({tag, " drained in time"}, {31'h0, (n < 5000)}, 32'h1);
    check({tag, " no pending bytes"}, exp_q.size(), 32'h0);
    check({tag, " busy low"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  d0;
    int          n, b0, pushed, outst, r;
    bit          we_seen, changed;

    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", {31'h0, in_ready}, 32'h1);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset count", {29'h0, count}, 32'h0);
    check("reset tx_we", {31'h0, tx_we}, 32'h0);
    check("reset tx_data", {24'h0, tx_data}, 32'h0);
    check("reset word_done", {31'h0, word_done}, 32'h0);
    rst = 1'b0;

    // Latency and basic byte order.
    done_cnt = 0;
    in_data = 32'h12345678;
    in_valid = 1'b1;
    expect_word(32'h12345678);
    step();
    in_valid = 1'b0;
    step();
    check("latency cycle1 we", {31'h0, tx_we}, 32'h0);
    step();
    check("latency cycle2 we", {31'h0, tx_we}, 32'h0);
    step();
    check("latency cycle3 we", {31'h0, tx_we}, 32'h1);
    drain("basic");
    check("basic word_done count", done_cnt, 32'd1);

    // Transmitter stalled for 1000 cycles before the first byte.
    tx_auto = 1'b0;
    tx_ready = 1'b0;
    d0 = tx_data;
    in_data = 32'hCAFEF00D;
    in_valid = 1'b1;
    expect_word(32'hCAFEF00D);
    step();
    in_valid = 1'b0;
    we_seen = 1'b0;
    changed = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (tx_we) we_seen = 1'b1;
      if (tx_data !== d0) changed = 1'b1;
    end
    check("stall tx_we stays low", {31'h0, we_seen}, 32'h0);
    check("stall tx_data stable", {31'h0, changed}, 32'h0);
    tx_phase = 0;
    tx_ready = 1'b1;
    tx_auto = 1'b1;
    drain("stall");

    // Fill the FIFO with the transmitter stalled, probe full, then refill on pop.
    done_cnt = 0;
    tx_auto = 1'b0;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w = {8'h40 + 8'(i), 8'h30 + 8'(i), 8'h20 + 8'(i), 8'hA0 + 8'(i)};
      check("fill in_ready", {31'h0, in_ready}, 32'h1);
      in_data = w;
      in_valid = 1'b1;
      expect_word(w);
      step();
    end
    in_data = 32'hEEEEEEEE;
    check("full count", {29'h0, count}, 32'd4);
    check("full in_ready", {31'h0, in_ready}, 32'h0);
    check("full busy", {31'h0, busy}, 32'h1);
    repeat (3) step();
    check("full count after ignored push", {29'h0, count}, 32'd4);
    w = {8'h45, 8'h35, 8'h25, 8'hA5};
    in_data = w;
    expect_word(w);
    tx_phase = 0;
    tx_ready = 1'b1;
    tx_auto = 1'b1;
    n = 0;
    while (!in_ready && n < 2000) begin
      step();
      n++;
    end
    check("refill accepted in time", {31'h0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    check("count after refill", {29'h0, count}, 32'd4);
    drain("full");
    check("full word_done count", done_cnt, 32'd6);

    // Reset in the middle of a word.
    in_data = 32'hDEADBEEF;
    in_valid = 1'b1;
    expect_word(32'hDEADBEEF);
    step();
    in_valid = 1'b0;
    b0 = byte_cnt;
    n = 0;
    while ((byte_cnt - b0) < 2 && n < 500) begin
      step();
      n++;
    end
    check("two bytes before reset", byte_cnt - b0, 32'd2);
    rst = 1'b1;
    #1;
    check("async reset tx_we", {31'h0, tx_we}, 32'h0);
    check("async reset tx_data", {24'h0, tx_data}, 32'h0);
    check("async reset busy", {31'h0, busy}, 32'h0);
    check("async reset count", {29'h0, count}, 32'h0);
    check("async reset in_ready", {31'h0, in_ready}, 32'h1);
    exp_q.delete();
    tx_phase = 0;
    tx_ready = 1'b1;
    we_prev = 1'b0;
    step();
    step();
    rst = 1'b0;
    done_cnt = 0;
    in_data = 32'h00000001;
    in_valid = 1'b1;
    expect_word(32'h00000001);
    step();
    in_valid = 1'b0;
    drain("post reset");
    check("post reset word_done count", done_cnt, 32'd1);

    // Random traffic against a randomly paced transmitter.
    tx_dly_max = 2;
    tx_len_min = 1;
    tx_len_max = 6;
    done_cnt = 0;
    pushed = 0;
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(3, 0));
      outst = pushed - done_cnt;
      if (r != 0 && outst < DEPTH) begin
        w = $urandom;
        check("random in_ready", {31'h0, in_ready}, 32'h1);
        in_data = w;
        in_valid = 1'b1;
        expect_word(w);
        pushed++;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    drain("random");
    check("random word_done count", done_cnt, pushed);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
